// File: rtl/core0_memsys_pkg.sv
// Shared types, default console addresses and MMIO decode for core0_memsys.
package core0_memsys_pkg;

  localparam int PKG_WORD_WIDTH = 32;

  localparam logic [PKG_WORD_WIDTH-1:0] DEFAULT_STDIN_ADDR  = 32'h8000_0000;
  localparam logic [PKG_WORD_WIDTH-1:0] DEFAULT_STDOUT_ADDR = 32'h8000_0001;

  typedef logic [PKG_WORD_WIDTH-1:0] console_word_t;

  // Classification of a main-memory access; CONSOLE means the one MMIO word
  // this port cares about (STDIN for reads, STDOUT for writes).
  typedef enum logic [1:0] {
    ACC_RAM        = 2'd0,
    ACC_CONSOLE    = 2'd1,
    ACC_MMIO_OTHER = 2'd2
  } access_kind_t;

  // Top address bit selects MMIO; inside MMIO only the console word is live.
  function automatic access_kind_t decode_access(input console_word_t addr,
                                                 input console_word_t console_addr);
    access_kind_t kind;
    if (!addr[PKG_WORD_WIDTH-1]) begin
      kind = ACC_RAM;
    end else if (addr == console_addr) begin
      kind = ACC_CONSOLE;
    end else begin
      kind = ACC_MMIO_OTHER;
    end
    return kind;
  endfunction

endpackage

// File: rtl/core0_memsys_fifo.sv
// Small synchronous FIFO used for the console RX and TX paths.
// The head word comes straight from storage registers, so a push is only
// visible on the cycle after it is written (no bypass).
module core0_memsys_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH_LOG = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 1 << DEPTH_LOG;

  logic [WIDTH-1:0]     store [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic [DEPTH_LOG:0]   count;
  logic                 do_pop;
  logic                 do_push;

  assign empty   = (count == '0);
  assign full    = (count == (DEPTH_LOG + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = store[rd_ptr];

  // Storage, pointers and occupancy; reset clears storage so the head reads 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/core0_memsys.sv
// core0 memory subsystem: byte-addressed program memory with unaligned
// multi-byte fetch, word-addressed main memory, and a memory-mapped console
// backed by RX/TX FIFOs that stalls the core when it cannot make progress.
module core0_memsys
  import core0_memsys_pkg::*;
#(
  parameter int WORD_MAG           = 5,
  localparam int WORD_WIDTH        = 1 << WORD_MAG,
  parameter int PROGRAM_ADDR_WIDTH = 11,
  parameter int MAIN_ADDR_WIDTH    = 11,
  parameter int FETCH_BYTES        = WORD_WIDTH / 8 + 1,
  parameter int FIFO_DEPTH_LOG     = 2,
  parameter logic [WORD_WIDTH-1:0] STDIN_ADDR  = DEFAULT_STDIN_ADDR,
  parameter logic [WORD_WIDTH-1:0] STDOUT_ADDR = DEFAULT_STDOUT_ADDR
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PROGRAM_ADDR_WIDTH-1:0] programmem_addr,
  output logic [FETCH_BYTES*8-1:0]      programmem_read_value,
  input  logic [PROGRAM_ADDR_WIDTH-1:0] programmem_write_addr,
  input  logic [WORD_WIDTH-1:0]         programmem_write_mask,
  input  logic [WORD_WIDTH-1:0]         programmem_write_value,
  input  logic                          programmem_we,
  input  logic [WORD_WIDTH-1:0]         mainmem_read_addr,
  input  logic                          mainmem_read_en,
  output logic [WORD_WIDTH-1:0]         mainmem_read_value,
  output logic                          mainmem_read_valid,
  input  logic [WORD_WIDTH-1:0]         mainmem_write_addr,
  input  logic [WORD_WIDTH-1:0]         mainmem_write_value,
  input  logic                          mainmem_we,
  output logic                          stall,
  input  logic [WORD_WIDTH-1:0]         rx_data,
  input  logic                          rx_valid,
  output logic                          rx_ready,
  output logic [WORD_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready
);

  localparam int WORD_BYTES   = WORD_WIDTH / 8;
  localparam int PROGRAM_SIZE = 1 << PROGRAM_ADDR_WIDTH;
  localparam int MAIN_SIZE    = 1 << MAIN_ADDR_WIDTH;

  logic [7:0]                 program_mem [PROGRAM_SIZE];
  logic [WORD_WIDTH-1:0]      main_mem    [MAIN_SIZE];

  access_kind_t               read_kind;
  access_kind_t               write_kind;
  logic [MAIN_ADDR_WIDTH-1:0] read_index;
  logic [MAIN_ADDR_WIDTH-1:0] write_index;
  logic                       read_accept;
  logic                       write_accept;
  logic                       ram_write;
  logic                       rx_pop;
  logic                       rx_push;
  logic                       tx_push;
  logic                       rx_empty;
  logic                       rx_full;
  logic                       tx_empty;
  logic                       tx_full;
  logic [WORD_WIDTH-1:0]      rx_head;
  logic [WORD_WIDTH-1:0]      read_data_next;

  assign read_kind   = decode_access(mainmem_read_addr, STDIN_ADDR);
  assign write_kind  = decode_access(mainmem_write_addr, STDOUT_ADDR);
  assign read_index  = mainmem_read_addr[MAIN_ADDR_WIDTH-1:0];
  assign write_index = mainmem_write_addr[MAIN_ADDR_WIDTH-1:0];

  // A stalled cycle must have no side effects, so every action below is
  // qualified by the accept signals, which are themselves held off in reset.
  assign stall = reset &&
                 ((mainmem_read_en && (read_kind == ACC_CONSOLE) && rx_empty) ||
                  (mainmem_we && (write_kind == ACC_CONSOLE) && tx_full));

  assign read_accept  = reset && mainmem_read_en && !stall;
  assign write_accept = reset && mainmem_we && !stall;
  assign ram_write    = write_accept && (write_kind == ACC_RAM);
  assign rx_pop       = read_accept && (read_kind == ACC_CONSOLE);
  assign tx_push      = write_accept && (write_kind == ACC_CONSOLE);

  assign rx_ready = reset && !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign tx_valid = !tx_empty;

  core0_memsys_fifo #(
    .WIDTH     (WORD_WIDTH),
    .DEPTH_LOG (FIFO_DEPTH_LOG)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .empty     (rx_empty),
    .full      (rx_full)
  );

  core0_memsys_fifo #(
    .WIDTH     (WORD_WIDTH),
    .DEPTH_LOG (FIFO_DEPTH_LOG)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (mainmem_write_value),
    .pop       (tx_ready),
    .head      (tx_data),
    .empty     (tx_empty),
    .full      (tx_full)
  );

  // Program fetch: gather FETCH_BYTES consecutive bytes, wrapping at the top.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      programmem_read_value <= '0;
    end else begin
      for (int i = 0; i < FETCH_BYTES; i++) begin
        programmem_read_value[8*i +: 8] <=
          program_mem[programmem_addr + PROGRAM_ADDR_WIDTH'(i)];
      end
    end
  end

  // Program write: bit-masked merge into WORD_BYTES consecutive bytes.
  always_ff @(posedge clk) begin
    if (reset && programmem_we) begin
      for (int j = 0; j < WORD_BYTES; j++) begin
        program_mem[programmem_write_addr + PROGRAM_ADDR_WIDTH'(j)] <=
          (programmem_write_value[8*j +: 8] & programmem_write_mask[8*j +: 8]) |
          (program_mem[programmem_write_addr + PROGRAM_ADDR_WIDTH'(j)] &
           ~programmem_write_mask[8*j +: 8]);
      end
    end
  end

  // Main RAM write port; array is left uninitialised so simulation can preload it.
  always_ff @(posedge clk) begin
    if (ram_write) begin
      main_mem[write_index] <= mainmem_write_value;
    end
  end

  // Select the read source: RAM word, RX head, or zero for other MMIO.
  always_comb begin
    read_data_next = '0;
    case (read_kind)
      ACC_RAM:     read_data_next = main_mem[read_index];
      ACC_CONSOLE: read_data_next = rx_head;
      default:     read_data_next = '0;
    endcase
  end

  // Main read response register, one cycle after acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mainmem_read_value <= '0;
      mainmem_read_valid <= 1'b0;
    end else begin
      mainmem_read_valid <= read_accept;
      if (read_accept) begin
        mainmem_read_value <= read_data_next;
      end
    end
  end

endmodule
